// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the two-requester multiplier scheduler.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int TIMEOUT_DEF = 80;

endpackage

// File: rtl/register_n.sv
// Generic enable register with async active-low clear.
module register_n #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/rr_arb2.sv
// Stateless 2-way round-robin arbiter; the priority pointer lives in the parent.
module rr_arb2
  import mult_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       en,
  output logic [1:0] grant,
  output logic       win_id
);

  always_comb begin
    win_id = REQ0;
    if (req == 2'b10)
      win_id = REQ1;
    else if (req == 2'b11)
      win_id = prio;

    grant = 2'b00;
    if (en && (req != 2'b00))
      grant = (win_id == REQ1) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler for the shared iterative multiplier, with launch,
// completion/timeout tracking and a tagged response channel.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a request; grant issued combinationally here
// S_LAUNCH | one-cycle mult_start to the datapath, timeout counter clear
// S_WAIT   | waiting for mult_done or timeout
// S_RESP   | response held on rsp_* until rsp_ready
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [WIDTH-1:0]   req_a0,
  input  logic [WIDTH-1:0]   req_b0,
  input  logic [WIDTH-1:0]   req_a1,
  input  logic [WIDTH-1:0]   req_b1,
  output logic               mult_start,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] mult_prod,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_prod,
  output logic               rsp_err,
  output logic               busy
);

  state_t            state, state_nxt;
  logic              prio;
  logic [TW-1:0]     cnt;
  logic [1:0]        grant;
  logic              win_id;
  logic              arb_en;
  logic              accept;
  logic              tmo_hit;
  logic              finish;
  logic [WIDTH-1:0]  op_a_d, op_b_d;
  logic [2*WIDTH-1:0] prod_d;

  // reset_n gates the grant so req_ready also reads 0 while held in reset
  assign arb_en = (state == S_IDLE) && reset_n;

  rr_arb2 u_arb (
    .req    (req_valid),
    .prio   (prio),
    .en     (arb_en),
    .grant  (grant),
    .win_id (win_id)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign tmo_hit   = (cnt == TW'(TIMEOUT - 1));
  assign finish    = (state == S_WAIT) && (mult_done || tmo_hit);
  assign op_a_d    = (win_id == REQ1) ? req_a1 : req_a0;
  assign op_b_d    = (win_id == REQ1) ? req_b1 : req_b0;
  assign prod_d    = mult_done ? mult_prod : '0;

  register_n #(.W(WIDTH)) u_reg_a (
    .clk(clk), .reset_n(reset_n), .en(accept), .d(op_a_d), .q(mult_a)
  );
  register_n #(.W(WIDTH)) u_reg_b (
    .clk(clk), .reset_n(reset_n), .en(accept), .d(op_b_d), .q(mult_b)
  );
  register_n #(.W(1)) u_reg_id (
    .clk(clk), .reset_n(reset_n), .en(accept), .d(win_id), .q(rsp_id)
  );
  // done takes precedence over a coincident timeout
  register_n #(.W(2*WIDTH)) u_reg_prod (
    .clk(clk), .reset_n(reset_n), .en(finish), .d(prod_d), .q(rsp_prod)
  );
  register_n #(.W(1)) u_reg_err (
    .clk(clk), .reset_n(reset_n), .en(finish), .d(!mult_done), .q(rsp_err)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept)    state_nxt = S_LAUNCH;
      S_LAUNCH:                state_nxt = S_WAIT;
      S_WAIT:   if (finish)    state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      prio       <= REQ0;
      cnt        <= '0;
      mult_start <= 1'b0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      mult_start <= (state_nxt == S_LAUNCH);
      rsp_valid  <= (state_nxt == S_RESP);
      busy       <= (state_nxt != S_IDLE);
      if (accept)
        prio <= ~win_id;
      if (state == S_LAUNCH)
        cnt <= '0;
      else if (state == S_WAIT)
        cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// Directed scoreboard bench for mult_sched with an in-line datapath model.
module tb_mult_sched;

  localparam int TIMEOUT = 80;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic        mult_start;
  logic [31:0] mult_a, mult_b;
  logic        mult_done;
  logic [63:0] mult_prod;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [63:0] rsp_prod;

  typedef struct packed {
    logic        id;
    logic [63:0] prod;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  mult_sched #(.WIDTH(32), .TIMEOUT(TIMEOUT), .TW(7)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_prod(mult_prod),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_prod(rsp_prod), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // lat < 0: datapath never completes; bp: extra RESP cycles with rsp_ready low
  task automatic do_txn(input logic [1:0] valid, input logic [31:0] a0v, input logic [31:0] b0v,
                        input logic [31:0] a1v, input logic [31:0] b1v, input logic exp_id,
                        input int lat, input int bp, input bit hold);
    exp_t        e;
    int          resp_k;
    bit          early, extra, unstable, rdy_seen;
    logic [63:0] pa;
    logic [63:0] h_prod;
    logic        h_id, h_err;
    req_valid = valid;
    req_a0 = a0v; req_b0 = b0v; req_a1 = a1v; req_b1 = b1v;
    #1;
    check("req_ready_grant", 64'(req_ready), exp_id ? 64'd2 : 64'd1);
    e.id   = exp_id;
    e.err  = (lat < 0);
    e.prod = (lat < 0) ? 64'd0 :
             (exp_id ? ({32'd0, a1v} * {32'd0, b1v}) : ({32'd0, a0v} * {32'd0, b0v}));
    sb_q.push_back(e);
    @(negedge clk);
    if (!hold) req_valid = 2'b00;
    check("mult_start", 64'(mult_start), 64'd1);
    check("mult_a", 64'(mult_a), 64'(exp_id ? a1v : a0v));
    check("mult_b", 64'(mult_b), 64'(exp_id ? b1v : b0v));
    check("req_ready_launch", 64'(req_ready), 64'd0);
    pa = {32'd0, mult_a} * {32'd0, mult_b};
    resp_k = (lat < 0) ? TIMEOUT + 1 : lat + 1;
    early = 1'b0; extra = 1'b0;
    for (int k = 1; k <= resp_k; k++) begin
      @(negedge clk);
      if (k < resp_k) begin
        early |= rsp_valid;
        extra |= mult_start;
      end
      if (k == lat) begin
        mult_done = 1'b1; mult_prod = pa;
      end else begin
        mult_done = 1'b0; mult_prod = 64'h0BAD_0BAD_0BAD_0BAD;
      end
    end
    check("no_early_rsp", 64'(early), 64'd0);
    check("single_start_pulse", 64'(extra), 64'd0);
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      check("rsp_id", 64'(rsp_id), 64'(e.id));
      check("rsp_prod", rsp_prod, e.prod);
      check("rsp_err", 64'(rsp_err), 64'(e.err));
    end
    h_prod = rsp_prod; h_id = rsp_id; h_err = rsp_err;
    unstable = 1'b0; rdy_seen = 1'b0;
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      unstable |= (rsp_valid !== 1'b1) || (rsp_prod !== h_prod) || (rsp_id !== h_id) || (rsp_err !== h_err);
      rdy_seen |= (req_ready !== 2'b00);
    end
    if (bp > 0) begin
      check("bp_rsp_stable", 64'(unstable), 64'd0);
      check("bp_req_ready_low", 64'(rdy_seen), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 2'b11;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    mult_done = 1'b0; mult_prod = '0; rsp_ready = 1'b0;
    #1;
    check("reset_ctrl", 64'({mult_start, rsp_valid, rsp_id, rsp_err, busy, req_ready}), 64'd0);
    check("reset_rsp_prod", rsp_prod, 64'd0);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;

    // single request
    do_txn(2'b01, 32'd7, 32'd6, 32'd0, 32'd0, 1'b0, 40, 0, 1'b0);

    // contention from reset: 0,1,0,1 with backpressure on the second
    reset_n = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    reset_n = 1'b1;
    do_txn(2'b11, 32'd3, 32'd5, 32'hFFFF_FFFF, 32'd2, 1'b0, 1, 0, 1'b1);
    do_txn(2'b11, 32'd3, 32'd5, 32'hFFFF_FFFF, 32'd2, 1'b1, 5, 10, 1'b1);
    do_txn(2'b11, 32'd3, 32'd5, 32'hFFFF_FFFF, 32'd2, 1'b0, 66, 0, 1'b1);
    do_txn(2'b11, 32'd3, 32'd5, 32'hFFFF_FFFF, 32'd2, 1'b1, 2, 0, 1'b0);

    // timeout, then a fresh request whose done collides with the timeout cycle
    do_txn(2'b10, 32'd0, 32'd0, 32'd9, 32'd9, 1'b1, -1, 0, 1'b0);
    do_txn(2'b01, 32'd123456, 32'd1000, 32'd0, 32'd0, 1'b0, TIMEOUT, 0, 1'b0);

    // stray done in IDLE
    mult_done = 1'b1; mult_prod = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    mult_done = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_no_rsp", 64'({rsp_valid, busy}), 64'd0);
    check("stray_prod_hold", rsp_prod, 64'd123456000);

    // both valid with pointer at 1
    do_txn(2'b11, 32'd11, 32'd11, 32'h0001_0000, 32'h0001_0000, 1'b1, 66, 0, 1'b0);

    // async reset mid-WAIT, pointer left at 1 by this grant
    req_valid = 2'b01; req_a0 = 32'd5; req_b0 = 32'd5;
    #1;
    check("pre_reset_grant", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 2'b11;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midwait_reset_ctrl", 64'({mult_start, rsp_valid, rsp_id, rsp_err, busy, req_ready}), 64'd0);
    check("midwait_reset_a", 64'({mult_a, mult_b}), 64'd0);
    check("midwait_reset_prod", rsp_prod, 64'd0);
    sb_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    do_txn(2'b11, 32'd21, 32'd2, 32'd99, 32'd99, 1'b0, 10, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_sched.md
# mult_sched

Two-requester scheduler for the shared iterative multiplier datapath (add/shift multiplier plus its control). Accepts multiply requests on two valid/ready ports, grants round-robin, and launches one operation at a time. It returns the 64-bit product on a single response channel tagged with the requester id, and aborts with an error flag if the datapath never signals completion.

## Interface
Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- TIMEOUT, 80, max cycles from launch to mult_done before abort (datapath worst case ≈ 66).
- TW, 7, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; at most one bit high.
- req_a0, req_b0  in  WIDTH  requester 0 operands.
- req_a1, req_b1  in  WIDTH  requester 1 operands.
- mult_start  out  1  one-cycle launch pulse to datapath (drives doMult).
- mult_a, mult_b  out  WIDTH  latched operands to datapath, stable from launch until done/abort.
- mult_done  in  1  datapath completion pulse.
- mult_prod  in  2*WIDTH  datapath product, valid in mult_done cycle.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester id of response.
- rsp_prod  out  2*WIDTH  product; zero when rsp_err=1.
- rsp_err  out  1  timeout abort flag.
- busy  out  1  high in any state but IDLE.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE: if any req_valid, grant winner: req_ready[win]=1 combinationally, same cycle; latch operands and id; go LAUNCH. Otherwise stay.
- Arbitration: if one valid, it wins. If both valid, winner = prio pointer. On every grant, pointer = ~winner. Pointer resets to 0.
- LAUNCH: mult_start=1 for exactly this cycle; clear timeout counter; go WAIT.
- WAIT: counter increments each cycle. If mult_done, capture mult_prod, rsp_err=0, go RESP. Otherwise, if counter == TIMEOUT-1, set rsp_err=1, rsp_prod=0, go RESP. If mult_done and the timeout coincide, done wins.
- RESP: rsp_valid=1. rsp_id, rsp_prod and rsp_err hold stable until rsp_ready. On rsp_ready, go IDLE. No grant in the RESP cycle.
- mult_done outside WAIT is ignored; no state change.
- req_ready low in every state except IDLE.
- Reset (any time, including mid-WAIT) forces:
  - state = IDLE, pointer = 0;
  - all outputs 0, including mult_a, mult_b, rsp_prod, rsp_id, rsp_err, busy, mult_start.
  - An in-flight datapath operation is abandoned; the datapath shares reset and clears too.

## Timing
- Accept to mult_start: 1 cycle (accept in cycle T, mult_start in T+1).
- mult_done in cycle D to rsp_valid: 1 cycle (registered, rsp_valid at D+1).
- Minimum request spacing: accept, LAUNCH, ≥1 WAIT, RESP. Back-to-back grants are ≥4 cycles apart, since RESP returns to IDLE before the next grant.
- Timeout: rsp_valid with rsp_err=1 at launch+TIMEOUT+1.
- All outputs are registered except req_ready, which is combinational from req_valid, state and pointer.

## Structure
- Package mult_sched_pkg holds:
  - state encoding constants: S_IDLE=2'd0, S_LAUNCH=2'd1, S_WAIT=2'd2, S_RESP=2'd3;
  - requester id constants: REQ0=1'b0, REQ1=1'b1;
  - default TIMEOUT value.
- Sub-module rr_arb2 is the 2-way round-robin arbiter.
  - Inputs: req[1:0], prio, en.
  - Outputs: grant[1:0], win_id.
  - Holds no state; the pointer register lives in the parent.
- Operand, id, product and err latches use register_n instances.

## Test plan
- Single request: req_valid=01, a0=7, b0=6. Required: req_ready=01 same cycle; mult_start next cycle with mult_a=7, mult_b=6. Datapath model returns 42 after 40 cycles; then rsp_valid with rsp_id=0, rsp_prod=42, rsp_err=0.
- Contention: req_valid=11 held continuously from reset. Required grant sequence 0,1,0,1. Products 3*5=15 (port 0) and 0xFFFFFFFF*2=0x1_FFFFFFFE (port 1) return with matching rsp_id.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid. rsp_prod, rsp_id and rsp_err must stay stable, and req_ready=00 throughout even with req_valid=11.
- Timeout: datapath model never asserts mult_done. Required: rsp_valid, rsp_err=1, rsp_prod=0 at launch+81 cycles; FSM then returns to IDLE and accepts a new request.
- Done/timeout collision and stray done:
  - mult_done exactly at counter=TIMEOUT-1 gives rsp_err=0 with the product.
  - mult_done pulsed in IDLE causes no rsp_valid.
- Async reset mid-WAIT: assert reset_n=0 between clock edges. All outputs go 0 immediately. After release, req_valid=11 grants port 0 first.
